// File: rtl/pipe_pkg.sv
// Shared definitions for the handshaked pipeline-stage register.
//   state_e      : occupancy-encoded stage state (EMPTY/ONE/FULL)
//   DEF_*        : default bundle and counter widths
//   *_INC_W      : increment widths of the stall and squash counters
//   sat_sum_w()  : adder width for a saturating counter, wide enough that
//                  an overflow past the counter maximum is always visible
package pipe_pkg;

    typedef enum logic [1:0] {
        ST_EMPTY = 2'd0,
        ST_ONE   = 2'd1,
        ST_FULL  = 2'd2
    } state_e;

    localparam int unsigned DEF_CTRL_W   = 10;
    localparam int unsigned DEF_DATA_W   = 48;
    localparam int unsigned DEF_CNT_W    = 16;
    localparam int unsigned STALL_INC_W  = 1;
    localparam int unsigned SQUASH_INC_W = 2;

    function automatic int unsigned sat_sum_w(input int unsigned cnt_w,
                                              input int unsigned inc_w);
        return ((cnt_w > inc_w) ? cnt_w : inc_w) + 1;
    endfunction

endpackage

// File: rtl/pipe_sat_counter.sv
// Saturating up-counter with synchronous active-high reset.
//   clk_i    : clock
//   reset_i  : synchronous reset, clears the count
//   inc_i    : amount to add this cycle
//   cnt_o    : registered count; sticks at 2^CNT_W-1, never wraps
module pipe_sat_counter
    import pipe_pkg::*;
#(
    parameter int unsigned CNT_W = DEF_CNT_W,
    parameter int unsigned INC_W = 1
) (
    input  logic             clk_i,
    input  logic             reset_i,
    input  logic [INC_W-1:0] inc_i,
    output logic [CNT_W-1:0] cnt_o
);

    localparam int unsigned SUM_W = sat_sum_w(CNT_W, INC_W);
    localparam logic [SUM_W-1:0] CNT_MAX = {{(SUM_W-CNT_W){1'b0}}, {CNT_W{1'b1}}};

    logic [CNT_W-1:0] cnt_q;
    logic [CNT_W-1:0] cnt_d;
    logic [SUM_W-1:0] sum;

    always_comb begin
        sum   = SUM_W'(cnt_q) + SUM_W'(inc_i);
        cnt_d = (sum > CNT_MAX) ? '1 : sum[CNT_W-1:0];
    end

    always_ff @(posedge clk_i) begin
        if (reset_i) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    assign cnt_o = cnt_q;

endmodule

// File: rtl/pipe_stage_skid.sv
// Handshaked pipeline-stage register carrying a control and a data bundle.
//   clk, reset            : clock, synchronous active-high reset
//   flush                 : discard every held entry and the incoming one
//   in_valid/in_ready     : upstream handshake, in_ctrl/in_data payload
//   out_valid/out_ready   : downstream handshake, out_ctrl/out_data payload
//   occupancy             : entries held (0..2)
//   stall_cnt, squash_cnt : saturating debug counters
// SKID=1 uses a main + skid register so in_ready is a pure state decode;
// SKID=0 uses a single register with pass-through ready.
module pipe_stage_skid
    import pipe_pkg::*;
#(
    parameter int unsigned CTRL_W = DEF_CTRL_W,
    parameter int unsigned DATA_W = DEF_DATA_W,
    parameter int unsigned SKID   = 1,
    parameter int unsigned CNT_W  = DEF_CNT_W
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              flush,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [CTRL_W-1:0] in_ctrl,
    input  logic [DATA_W-1:0] in_data,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [CTRL_W-1:0] out_ctrl,
    output logic [DATA_W-1:0] out_data,
    output logic [1:0]        occupancy,
    output logic [CNT_W-1:0]  stall_cnt,
    output logic [CNT_W-1:0]  squash_cnt
);

    logic [CTRL_W-1:0] main_ctrl_q;
    logic [DATA_W-1:0] main_data_q;
    logic              retire;
    logic              stall_inc;
    logic [1:0]        squash_inc;

    generate
        if (SKID != 0) begin : g_skid
            state_e            state_q;
            logic [CTRL_W-1:0] skid_ctrl_q;
            logic [DATA_W-1:0] skid_data_q;

            // main_ctrl_q is zeroed on every transition into EMPTY so that
            // out_ctrl needs no output gating.
            always_ff @(posedge clk) begin
                if (reset) begin
                    state_q     <= ST_EMPTY;
                    main_ctrl_q <= '0;
                    main_data_q <= '0;
                    skid_ctrl_q <= '0;
                    skid_data_q <= '0;
                end else if (flush) begin
                    state_q     <= ST_EMPTY;
                    main_ctrl_q <= '0;
                end else begin
                    case (state_q)
                        ST_EMPTY: begin
                            if (in_valid) begin
                                main_ctrl_q <= in_ctrl;
                                main_data_q <= in_data;
                                state_q     <= ST_ONE;
                            end
                        end
                        ST_ONE: begin
                            if (in_valid && out_ready) begin
                                main_ctrl_q <= in_ctrl;
                                main_data_q <= in_data;
                            end else if (in_valid) begin
                                skid_ctrl_q <= in_ctrl;
                                skid_data_q <= in_data;
                                state_q     <= ST_FULL;
                            end else if (out_ready) begin
                                main_ctrl_q <= '0;
                                state_q     <= ST_EMPTY;
                            end
                        end
                        ST_FULL: begin
                            if (out_ready) begin
                                main_ctrl_q <= skid_ctrl_q;
                                main_data_q <= skid_data_q;
                                state_q     <= ST_ONE;
                            end
                        end
                        default: begin
                            main_ctrl_q <= '0;
                            state_q     <= ST_EMPTY;
                        end
                    endcase
                end
            end

            assign in_ready  = (state_q != ST_FULL);
            assign out_valid = (state_q != ST_EMPTY);
            assign occupancy = state_q;
        end else begin : g_pass
            logic valid_q;

            always_ff @(posedge clk) begin
                if (reset) begin
                    valid_q     <= 1'b0;
                    main_ctrl_q <= '0;
                    main_data_q <= '0;
                end else if (flush) begin
                    valid_q     <= 1'b0;
                    main_ctrl_q <= '0;
                end else if (in_valid && in_ready) begin
                    valid_q     <= 1'b1;
                    main_ctrl_q <= in_ctrl;
                    main_data_q <= in_data;
                end else if (valid_q && out_ready) begin
                    valid_q     <= 1'b0;
                    main_ctrl_q <= '0;
                end
            end

            assign in_ready  = !valid_q || out_ready;
            assign out_valid = valid_q;
            assign occupancy = {1'b0, valid_q};
        end
    endgenerate

    assign out_ctrl = main_ctrl_q;
    assign out_data = main_data_q;

    // An entry retiring in the flush cycle reached downstream, so it is
    // subtracted from the squash count.
    always_comb begin
        retire     = out_valid && out_ready;
        stall_inc  = out_valid && !out_ready;
        squash_inc = flush ? (occupancy - {1'b0, retire}) : 2'd0;
    end

    pipe_sat_counter #(
        .CNT_W (CNT_W),
        .INC_W (STALL_INC_W)
    ) u_stall_cnt (
        .clk_i   (clk),
        .reset_i (reset),
        .inc_i   (stall_inc),
        .cnt_o   (stall_cnt)
    );

    pipe_sat_counter #(
        .CNT_W (CNT_W),
        .INC_W (SQUASH_INC_W)
    ) u_squash_cnt (
        .clk_i   (clk),
        .reset_i (reset),
        .inc_i   (squash_inc),
        .cnt_o   (squash_cnt)
    );

endmodule

// File: tb/tb_pipe_stage_skid.sv
module tb_pipe_stage_skid;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic        reset, flush, in_valid, out_ready;
    logic [9:0]  in_ctrl;
    logic [47:0] in_data;

    // SKID=1, default widths
    logic        m_in_ready, m_out_valid;
    logic [9:0]  m_out_ctrl;
    logic [47:0] m_out_data;
    logic [1:0]  m_occ;
    logic [15:0] m_stall, m_squash;

    // SKID=0
    logic        z_in_ready, z_out_valid;
    logic [9:0]  z_out_ctrl;
    logic [47:0] z_out_data;
    logic [1:0]  z_occ;
    logic [15:0] z_stall, z_squash;

    // SKID=1, CNT_W=4
    logic        s_in_ready, s_out_valid;
    logic [9:0]  s_out_ctrl;
    logic [47:0] s_out_data;
    logic [1:0]  s_occ;
    logic [3:0]  s_stall, s_squash;

    pipe_stage_skid dut (
        .clk(clk), .reset(reset), .flush(flush),
        .in_valid(in_valid), .in_ready(m_in_ready), .in_ctrl(in_ctrl), .in_data(in_data),
        .out_valid(m_out_valid), .out_ready(out_ready), .out_ctrl(m_out_ctrl), .out_data(m_out_data),
        .occupancy(m_occ), .stall_cnt(m_stall), .squash_cnt(m_squash)
    );

    pipe_stage_skid #(.SKID(0)) dut0 (
        .clk(clk), .reset(reset), .flush(flush),
        .in_valid(in_valid), .in_ready(z_in_ready), .in_ctrl(in_ctrl), .in_data(in_data),
        .out_valid(z_out_valid), .out_ready(out_ready), .out_ctrl(z_out_ctrl), .out_data(z_out_data),
        .occupancy(z_occ), .stall_cnt(z_stall), .squash_cnt(z_squash)
    );

    pipe_stage_skid #(.CNT_W(4)) dut4 (
        .clk(clk), .reset(reset), .flush(flush),
        .in_valid(in_valid), .in_ready(s_in_ready), .in_ctrl(in_ctrl), .in_data(in_data),
        .out_valid(s_out_valid), .out_ready(out_ready), .out_ctrl(s_out_ctrl), .out_data(s_out_data),
        .occupancy(s_occ), .stall_cnt(s_stall), .squash_cnt(s_squash)
    );

    int tests = 0;
    int fails = 0;
    logic [57:0] sb_q[$];
    logic [57:0] exp_e;

    function automatic logic [9:0] ctrl_of(input logic [47:0] d);
        return d[9:0] ^ 10'h2A5;
    endfunction

    task automatic drive(input logic v, input logic [47:0] d);
        in_valid = v;
        in_data  = d;
        in_ctrl  = ctrl_of(d);
    endtask

    // One clock: scoreboard bookkeeping for dut at the falling edge, then
    // return 1 time unit after the rising edge.
    task automatic cycle();
        @(negedge clk);
        if (reset) begin
            sb_q.delete();
        end else begin
            if (m_out_valid && out_ready) begin
                tests++;
                if (sb_q.size() == 0) begin
                    fails++;
                    $display("FAIL sb_underflow: retired ctrl=%h data=%h, required no entry", m_out_ctrl, m_out_data);
                end else begin
                    exp_e = sb_q.pop_front();
                    if ({m_out_ctrl, m_out_data} !== exp_e) begin
                        fails++;
                        $display("FAIL sb_order: got %h, required %h", {m_out_ctrl, m_out_data}, exp_e);
                    end
                end
            end
            if (flush) sb_q.delete();
            else if (in_valid && m_in_ready) sb_q.push_back({in_ctrl, in_data});
        end
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        reset = 1'b1; flush = 1'b0; out_ready = 1'b0; drive(1'b0, 48'h0);
        cycle(); cycle();
        reset = 1'b0;
        tests++; if (m_out_valid !== 1'b0) begin fails++; $display("FAIL rst_valid: got %b required 0", m_out_valid); end
        tests++; if (m_out_ctrl !== 10'h0) begin fails++; $display("FAIL rst_ctrl: got %h required 0", m_out_ctrl); end
        tests++; if (m_out_data !== 48'h0) begin fails++; $display("FAIL rst_data: got %h required 0", m_out_data); end
        tests++; if (m_occ !== 2'd0) begin fails++; $display("FAIL rst_occ: got %0d required 0", m_occ); end
        tests++; if (m_stall !== 16'd0 || m_squash !== 16'd0) begin fails++; $display("FAIL rst_cnt: got %0d/%0d required 0/0", m_stall, m_squash); end
        tests++; if (m_in_ready !== 1'b1) begin fails++; $display("FAIL rst_in_ready: got %b required 1", m_in_ready); end
    endtask

    task automatic test_stream();
        out_ready = 1'b1;
        for (int i = 1; i <= 5; i++) begin
            drive(1'b1, 48'(i));
            cycle();
            tests++; if (m_out_data !== 48'(i) || m_out_valid !== 1'b1) begin fails++; $display("FAIL stream_data: got v=%b %h required v=1 %h", m_out_valid, m_out_data, 48'(i)); end
            tests++; if (m_in_ready !== 1'b1 || m_occ !== 2'd1) begin fails++; $display("FAIL stream_rdy_occ: got rdy=%b occ=%0d required 1/1", m_in_ready, m_occ); end
        end
        drive(1'b0, 48'h0);
        cycle();
        tests++; if (m_occ !== 2'd0 || m_out_ctrl !== 10'h0) begin fails++; $display("FAIL stream_drain: got occ=%0d ctrl=%h required 0/0", m_occ, m_out_ctrl); end
        tests++; if (m_stall !== 16'd0) begin fails++; $display("FAIL stream_stall: got %0d required 0", m_stall); end
    endtask

    task automatic test_backpressure();
        out_ready = 1'b1; drive(1'b1, 48'hA1); cycle();
        out_ready = 1'b0; drive(1'b1, 48'hB2); cycle();
        tests++; if (m_in_ready !== 1'b0 || m_occ !== 2'd2) begin fails++; $display("FAIL bp_full: got rdy=%b occ=%0d required 0/2", m_in_ready, m_occ); end
        tests++; if (m_out_data !== 48'hA1) begin fails++; $display("FAIL bp_hold: got %h required a1", m_out_data); end
        drive(1'b0, 48'h0); cycle(); cycle();
        tests++; if (m_out_data !== 48'hA1 || m_out_valid !== 1'b1) begin fails++; $display("FAIL bp_hold2: got v=%b %h required v=1 a1", m_out_valid, m_out_data); end
        out_ready = 1'b1; cycle();
        tests++; if (m_out_data !== 48'hB2 || m_in_ready !== 1'b1) begin fails++; $display("FAIL bp_skid_out: got %h rdy=%b required b2 rdy=1", m_out_data, m_in_ready); end
        cycle();
        tests++; if (m_occ !== 2'd0) begin fails++; $display("FAIL bp_empty: got occ=%0d required 0", m_occ); end
        tests++; if (m_stall !== 16'd3) begin fails++; $display("FAIL bp_stall: got %0d required 3", m_stall); end
        tests++; if (sb_q.size() != 0) begin fails++; $display("FAIL bp_lost: got %0d pending entries required 0", sb_q.size()); end
    endtask

    task automatic test_flush_full();
        out_ready = 1'b1; drive(1'b1, 48'hC1); cycle();
        out_ready = 1'b0; drive(1'b1, 48'hD2); cycle();
        flush = 1'b1; drive(1'b1, 48'hE3); cycle();
        flush = 1'b0; drive(1'b0, 48'h0);
        tests++; if (m_out_valid !== 1'b0 || m_out_ctrl !== 10'h0 || m_occ !== 2'd0) begin fails++; $display("FAIL flush_full_state: got v=%b ctrl=%h occ=%0d required 0/0/0", m_out_valid, m_out_ctrl, m_occ); end
        tests++; if (m_squash !== 16'd2) begin fails++; $display("FAIL flush_full_squash: got %0d required 2", m_squash); end
        tests++; if (m_stall !== 16'd5) begin fails++; $display("FAIL flush_full_stall: got %0d required 5", m_stall); end
        out_ready = 1'b1; cycle();
        tests++; if (m_out_valid !== 1'b0) begin fails++; $display("FAIL flush_drop_in: got v=%b required 0", m_out_valid); end
    endtask

    task automatic test_flush_retire();
        out_ready = 1'b1; drive(1'b1, 48'hF4); cycle();
        flush = 1'b1; drive(1'b0, 48'h0); cycle();
        flush = 1'b0;
        tests++; if (m_squash !== 16'd2 || m_occ !== 2'd0) begin fails++; $display("FAIL flush_retire: got squash=%0d occ=%0d required 2/0", m_squash, m_occ); end
        drive(1'b1, 48'h65); cycle();
        out_ready = 1'b0; flush = 1'b1; drive(1'b0, 48'h0); cycle();
        flush = 1'b0;
        tests++; if (m_squash !== 16'd3 || m_stall !== 16'd6) begin fails++; $display("FAIL flush_one: got squash=%0d stall=%0d required 3/6", m_squash, m_stall); end
    endtask

    task automatic test_skid0();
        reset = 1'b1; drive(1'b0, 48'h0); cycle();
        reset = 1'b0;
        out_ready = 1'b1; drive(1'b1, 48'h11); cycle();
        drive(1'b1, 48'h22); #1;
        tests++; if (z_in_ready !== 1'b1) begin fails++; $display("FAIL s0_ready_pass: got %b required 1", z_in_ready); end
        cycle();
        tests++; if (z_out_data !== 48'h22 || z_out_ctrl !== ctrl_of(48'h22) || z_occ !== 2'd1) begin fails++; $display("FAIL s0_next: got %h ctrl=%h occ=%0d required 22 %h 1", z_out_data, z_out_ctrl, z_occ, ctrl_of(48'h22)); end
        out_ready = 1'b0; drive(1'b1, 48'h33); #1;
        tests++; if (z_in_ready !== 1'b0) begin fails++; $display("FAIL s0_ready_block: got %b required 0", z_in_ready); end
        cycle();
        tests++; if (z_out_data !== 48'h22 || z_stall !== 16'd1) begin fails++; $display("FAIL s0_hold: got %h stall=%0d required 22/1", z_out_data, z_stall); end
        out_ready = 1'b1; drive(1'b0, 48'h0); cycle();
        tests++; if (z_out_valid !== 1'b0 || z_out_ctrl !== 10'h0 || z_out_data !== 48'h22) begin fails++; $display("FAIL s0_empty: got v=%b ctrl=%h data=%h required 0/0/22", z_out_valid, z_out_ctrl, z_out_data); end
    endtask

    task automatic test_cnt_sat();
        reset = 1'b1; drive(1'b0, 48'h0); cycle();
        reset = 1'b0;
        out_ready = 1'b1; drive(1'b1, 48'h44); cycle();
        out_ready = 1'b0; drive(1'b0, 48'h0);
        repeat (15) cycle();
        tests++; if (s_stall !== 4'd15) begin fails++; $display("FAIL sat_reach: got %0d required 15", s_stall); end
        repeat (5) cycle();
        tests++; if (s_stall !== 4'd15) begin fails++; $display("FAIL sat_hold: got %0d required 15", s_stall); end
        drive(1'b1, 48'h55); cycle();
        tests++; if (s_occ !== 2'd2) begin fails++; $display("FAIL sat_full: got occ=%0d required 2", s_occ); end
        reset = 1'b1; drive(1'b0, 48'h0); cycle();
        reset = 1'b0;
        tests++; if (s_out_valid !== 1'b0 || s_out_ctrl !== 10'h0 || s_out_data !== 48'h0 || s_occ !== 2'd0) begin fails++; $display("FAIL mid_rst_out: got v=%b ctrl=%h data=%h occ=%0d required all 0", s_out_valid, s_out_ctrl, s_out_data, s_occ); end
        tests++; if (s_stall !== 4'd0 || s_squash !== 4'd0 || s_in_ready !== 1'b1) begin fails++; $display("FAIL mid_rst_cnt: got stall=%0d squash=%0d rdy=%b required 0/0/1", s_stall, s_squash, s_in_ready); end
    endtask

    initial begin
        reset = 1'b1; flush = 1'b0; out_ready = 1'b0;
        in_valid = 1'b0; in_ctrl = '0; in_data = '0;
        test_reset();
        test_stream();
        test_backpressure();
        test_flush_full();
        test_flush_retire();
        test_skid0();
        test_cnt_sat();
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule

// File: doc/pipe_stage_skid.md
# pipe_stage_skid

Parametrised, handshaked pipeline-stage register that replaces the fixed, always-advancing inter-stage registers of the 8-bit pipeline. It carries a CTRL_W-bit control bundle and a DATA_W-bit data bundle between two stages. It uses valid/ready flow control with an optional 2-entry skid buffer, so that `in_ready` is a pure register output. It also provides synchronous flush (bubble insertion) and saturating stall and squash counters for debug.

## Interface
- CTRL_W, 10: width of the control bundle (write enables, selects, branch/ret flags).
- DATA_W, 48: width of the data bundle (ALU result, store data, address, instruction, register IDs).
- SKID, 1: 1 selects the 2-entry skid mode; 0 selects the 1-entry pass-through-ready mode.
- CNT_W, 16: width of the debug counters.
- clk  in  1  clock; all state updates on the rising edge.
- reset  in  1  synchronous, active-high reset.
- flush  in  1  squash all held entries this cycle.
- in_valid  in  1  upstream entry present.
- in_ready  out  1  stage can accept this cycle.
- in_ctrl  in  CTRL_W  upstream control bundle.
- in_data  in  DATA_W  upstream data bundle.
- out_valid  out  1  downstream entry present.
- out_ready  in  1  downstream accepts this cycle.
- out_ctrl  out  CTRL_W  control bundle; all-zero whenever out_valid=0.
- out_data  out  DATA_W  data bundle.
- occupancy  out  2  entries held (0..2; max 1 when SKID=0).
- stall_cnt  out  CNT_W  cycles with out_valid & !out_ready; saturating.
- squash_cnt  out  CNT_W  entries discarded by flush; saturating.

## Operation
- Handshake terms: accept = in_valid & in_ready; retire = out_valid & out_ready. out_valid/out_ctrl/out_data never change while out_valid & !out_ready.
- SKID=1, states EMPTY(0)/ONE(1)/FULL(2). occupancy = state. in_ready = (state != FULL), decoded from the state register only.
  - EMPTY: on in_valid, main <= in and go to ONE.
  - ONE, in_valid & out_ready: main <= in, stay in ONE.
  - ONE, in_valid & !out_ready: skid <= in, go to FULL.
  - ONE, !in_valid & out_ready: go to EMPTY.
  - ONE, otherwise: hold.
  - FULL, out_ready: main <= skid, go to ONE. No accept is possible in FULL.
  - FULL, otherwise: hold.
- SKID=0: single main register. in_ready = !out_valid | out_ready (combinational). On accept, main <= in. On retire without accept, out_valid <= 0.
- Main-register ctrl is written as zero whenever the main register becomes empty, so out_ctrl=0 whenever out_valid=0. out_data holds its last value.
- Flush has priority over all transitions:
  - State goes to EMPTY and out_valid goes to 0 next cycle; out_ctrl is 0.
  - The in_valid of that cycle is dropped.
  - A simultaneous retire still counts as delivered downstream.
  - squash_cnt += occupancy minus (1 if retire that cycle).
- stall_cnt increments each cycle with out_valid & !out_ready, including the cycle a flush arrives.
- Both counters stop at 2^CNT_W−1 and never wrap.
- Reset: state EMPTY, out_valid 0, out_ctrl 0, out_data 0, skid 0, occupancy 0, both counters 0. in_ready reads 1 in the cycle after reset deasserts. Reset asserted mid-transfer discards all entries; no squash is counted.

## Timing
- Latency: an entry accepted at edge N is presented on out_* after edge N.
- Throughput: 1 entry/cycle sustained when out_ready=1.
- SKID=1: in_ready falls the cycle after the second entry is buffered. The entry accepted in the cycle out_ready dropped is kept, never lost.
- flush takes effect at the edge it is sampled; no multi-cycle drain.
- Counters update at the same edge as the event; their outputs are registered.

## Structure
- Shared package `pipe_pkg` holds:
  - state encoding constants ST_EMPTY=2'd0, ST_ONE=2'd1, ST_FULL=2'd2;
  - default width constants;
  - the saturating-increment width rule.
- Sub-module `pipe_sat_counter` (params CNT_W, INC_W) implements a saturating add with synchronous reset. It is instantiated twice: stall (INC_W=1) and squash (INC_W=2).
- The skid register is generated only when SKID=1.

## Test plan
- Reset then stream: reset=1 for 2 cycles, then in_valid=1 with data 0x01..0x05 and out_ready=1 -> out_data 0x01..0x05 on consecutive cycles, one cycle after each accept; in_ready stays 1; occupancy stays at 1.
- Backpressure (SKID=1): with ONE holding 0xA1, out_ready=0 and in 0xB2 -> FULL, in_ready=0, out_data holds 0xA1. Then out_ready=1 -> 0xA1 and 0xB2 retire in order with nothing lost; stall_cnt = number of stalled cycles.
- Flush in FULL with out_ready=0 and in_valid=1 -> next cycle out_valid=0, out_ctrl=0, occupancy=0, the in_valid entry is not captured, squash_cnt=2.
- Flush with simultaneous retire in ONE -> the entry is counted as delivered and squash_cnt is unchanged.
- SKID=0, out_valid=1, out_ready=1, in_valid=1 -> in_ready=1 in the same cycle and the new data appears next cycle; with out_ready=0, in_ready=0.
- CNT_W=4: hold out_ready=0 for 20 cycles -> stall_cnt saturates at 15. Then assert reset mid-stall -> all outputs return to reset values the next cycle and squash_cnt=0.
